// File: rtl/bounce_if.sv
// bounce_if: command-level and emulated-pin bundle between a test controller and the bounce emulator
interface bounce_if;
  logic       level_in;
  logic       en;
  logic       sw_low;
  logic       busy;
  logic [7:0] bounce_cnt;
  modport master(output level_in, en, input sw_low, busy, bounce_cnt);
  modport slave(input level_in, en, output sw_low, busy, bounce_cnt);
endinterface

// File: rtl/bounce_emulator.sv
// bounce_emulator: turns a clean command level into an active-low switch pin that chatters for a fixed window after each change
module bounce_emulator #(
  parameter int          BOUNCE_W = 20,
  parameter int          TOGGLE_W = 12,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic     clk,
  input logic     rst,
  bounce_if.slave bus
);
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h0001 : SEED;
  typedef enum logic {IDLE, BOUNCE} state_t;
  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic                settled_q, settled_d;
  logic                target_q, target_d;
  logic [BOUNCE_W-1:0] win_q, win_d;
  logic [TOGGLE_W-1:0] tmr_q, tmr_d;
  logic                sw_q, sw_d;
  logic                busy_q, busy_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TOGGLE_W-1:0] tmr_rel;
  logic                tick;
  assign tmr_rel = lfsr_q[TOGGLE_W-1:0] | TOGGLE_W'(1);
  assign tick = tmr_q == TOGGLE_W'(1);
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    state_d   = state_q;
    settled_d = settled_q;
    target_d  = target_q;
    win_d     = win_q;
    tmr_d     = tmr_q;
    sw_d      = sw_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE) begin
      if (bus.level_in != settled_q && bus.en) begin
        target_d = bus.level_in;
        sw_d     = !sw_q;
        cnt_d    = 8'd1;
        win_d    = '0;
        tmr_d    = tmr_rel;
        busy_d   = 1'b1;
        state_d  = BOUNCE;
      end else if (bus.level_in != settled_q) begin
        settled_d = bus.level_in;
        sw_d      = !bus.level_in;
        cnt_d     = 8'd0;
      end else begin
        sw_d = !settled_q;
      end
    end else if (&win_q) begin
      sw_d      = !target_q;
      settled_d = target_q;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end else begin
      win_d = win_q + BOUNCE_W'(1);
      tmr_d = tick ? tmr_rel : tmr_q - TOGGLE_W'(1);
      sw_d  = tick ? !sw_q : sw_q;
      cnt_d = (tick && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_NZ;
      settled_q <= 1'b0;
      target_q  <= 1'b0;
      win_q     <= '0;
      tmr_q     <= '0;
      sw_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      settled_q <= settled_d;
      target_q  <= target_d;
      win_q     <= win_d;
      tmr_q     <= tmr_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.sw_low     = sw_q;
  assign bus.busy       = busy_q;
  assign bus.bounce_cnt = cnt_q;
endmodule
